// File: rtl/aes_pkg.sv
// AES-128 shared types, S-box tables and GF(2^8) helpers for the round datapath.
package aes_pkg;

    typedef logic [15:0][7:0] state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Byte n lives at bits [127-8n -: 8]; s[n] is state element row n%4, column n/4.
    function automatic state_t to_state(input logic [127:0] d);
        state_t s;
        for (int n = 0; n < 16; n++) s[n] = d[127-8*n -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input state_t s);
        logic [127:0] d;
        for (int n = 0; n < 16; n++) d[127-8*n -: 8] = s[n];
        return d;
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// One AES column through MixColumns (inv=0) or InvMixColumns (inv=1).
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] b    [4];
    logic [7:0] coef [4];
    logic [7:0] acc;

    // Circulant matrix: output row r = sum_k coef[k] * b[(r+k) mod 4].
    always_comb begin
        col_out = '0;
        acc     = '0;
        for (int r = 0; r < 4; r++) b[r] = col_in[31-8*r -: 8];
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(b[(r+k)%4], coef[k]);
            col_out[31-8*r -: 8] = acc;
        end
    end

endmodule

// File: rtl/general_round_de.sv
// Single AES-128 round (encrypt or straight inverse) with one registered output stage.
// Optional macro AES_LAST_ROUND_EN adds last_round to bypass (Inv)MixColumns.
module general_round_de
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         encrypt,
`ifdef AES_LAST_ROUND_EN
    input  logic         last_round,
`endif
    input  logic [127:0] keyword,
    input  logic [127:0] input_data,
    output logic [127:0] result,
    output logic         out_valid
);

    function automatic state_t sub_bytes(input state_t s, input logic inv);
        state_t o;
        for (int n = 0; n < 16; n++) o[n] = inv ? INV_SBOX[s[n]] : SBOX[s[n]];
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s, input logic inv);
        state_t o;
        int     src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[4*c+r] = s[4*src+r];
            end
        end
        return o;
    endfunction

    logic         last_rnd;
    logic [127:0] mix_in;
    logic [127:0] mix_out;
    logic [127:0] mixed;
    logic [127:0] round_p0;
    logic [127:0] result_p1;
    logic         vld_p1;

`ifdef AES_LAST_ROUND_EN
    assign last_rnd = last_round;
`else
    assign last_rnd = 1'b0;
`endif

    // Both directions share the column mixers: encrypt feeds ShiftRows(SubBytes(x)), decrypt feeds x ^ key.
    assign mix_in = encrypt ? from_state(shift_rows(sub_bytes(to_state(input_data), 1'b0), 1'b0))
                            : (input_data ^ keyword);

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_mix_column u_mix (
            .col_in  (mix_in[127-32*c -: 32]),
            .inv     (~encrypt),
            .col_out (mix_out[127-32*c -: 32])
        );
    end

    assign mixed    = last_rnd ? mix_in : mix_out;
    assign round_p0 = encrypt ? (mixed ^ keyword)
                              : from_state(sub_bytes(shift_rows(to_state(mixed), 1'b1), 1'b1));

    // p0 -> p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) result_p1 <= round_p0;
        end
    end

    assign result    = result_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_general_round_de.sv
// Randomized bench for general_round_de against an arithmetic AES round model.
module tb_general_round_de;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         encrypt = 1'b0;
    logic         last_round = 1'b0;
    logic [127:0] keyword = '0;
    logic [127:0] input_data = '0;
    logic [127:0] result;
    logic         out_valid;

    always #5 clk = ~clk;

    general_round_de dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .encrypt    (encrypt),
`ifdef AES_LAST_ROUND_EN
        .last_round (last_round),
`endif
        .keyword    (keyword),
        .input_data (input_data),
        .result     (result),
        .out_valid  (out_valid)
    );

    int           cmp_cnt = 0;
    int           err_cnt = 0;
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] exp_result = '0;
    logic         exp_valid = 1'b0;
    logic         armed = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        p  = '0;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_round(input logic enc, input logic lr,
                                                 input logic [127:0] key, input logic [127:0] data);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] cf [4];
        logic [127:0] d;
        d = enc ? data : (data ^ key);
        for (int n = 0; n < 16; n++) b[n] = d[127-8*n -: 8];
        if (enc) begin
            for (int n = 0; n < 16; n++) t[n] = sb[b[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) b[4*c+r] = t[4*((c+r)%4)+r];
        end
        if (!lr) begin
            if (enc) cf = '{8'h02, 8'h03, 8'h01, 8'h01};
            else     cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    t[4*c+r] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        t[4*c+r] = t[4*c+r] ^ gmul(cf[(j-r+4)%4], b[4*c+j]);
                end
            for (int n = 0; n < 16; n++) b[n] = t[n];
        end
        if (!enc) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c-r+4)%4)+r];
            for (int n = 0; n < 16; n++) b[n] = isb[t[n]];
        end
        for (int n = 0; n < 16; n++) d[127-8*n -: 8] = b[n];
        return enc ? (d ^ key) : d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_result = '0;
            exp_valid  = 1'b0;
            armed      = 1'b1;
        end else begin
            exp_valid = in_valid;
            if (in_valid) exp_result = model_round(encrypt, last_round, keyword, input_data);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            cmp_cnt++;
            if (out_valid !== exp_valid) begin
                err_cnt++;
                $display("FAIL model_valid t=%0t got=%b want=%b", $time, out_valid, exp_valid);
            end
            cmp_cnt++;
            if (result !== exp_result) begin
                err_cnt++;
                $display("FAIL model_result t=%0t got=%h want=%h", $time, result, exp_result);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic e, input logic lr,
                         input logic [127:0] k, input logic [127:0] d);
        #1;
        rst        = r;
        in_valid   = v;
        encrypt    = e;
        last_round = lr;
        keyword    = k;
        input_data = d;
    endtask

    task automatic check_lit(input string name, input logic [127:0] want_r, input logic want_v);
        cmp_cnt++;
        if (result !== want_r || out_valid !== want_v) begin
            err_cnt++;
            $display("FAIL %s got=%h/%b want=%h/%b", name, result, out_valid, want_r, want_v);
        end
    endtask

    localparam logic [127:0] K1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] P0  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C1  = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] K2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    localparam logic [127:0] C2  = 128'h4915598f55e5d7a0daca94fa1f0a63f7;
    localparam logic [127:0] Z63 = {16{8'h63}};

    initial begin
        logic [127:0] m;
        build_sbox();
        m = model_round(1'b1, 1'b0, '0, '0);
        cmp_cnt++;
        if (m !== Z63) begin
            err_cnt++;
            $display("FAIL model_zero got=%h want=%h", m, Z63);
        end

        repeat (2) @(negedge clk);
        check_lit("reset_state", '0, 1'b0);
        drive(0, 0, 0, 0, '0, '0);
        @(negedge clk); check_lit("idle_after_reset", '0, 1'b0);

        drive(0, 1, 1, 0, '0, '0);
        @(negedge clk); check_lit("enc_zero", Z63, 1'b1);
        drive(0, 1, 0, 0, K1, C1);
        @(negedge clk); check_lit("dec_k1", P0, 1'b1);
        drive(0, 1, 1, 0, K1, P0);
        @(negedge clk); check_lit("enc_k1", C1, 1'b1);
        drive(0, 1, 1, 0, K2, C1);
        @(negedge clk); check_lit("enc_k2", C2, 1'b1);
        drive(0, 1, 0, 0, K2, C2);
        @(negedge clk); check_lit("dec_k2_b2b", C1, 1'b1);
        drive(0, 0, 1, 0, K2, $urandom());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check_lit("hold", C1, 1'b0);
        end

`ifdef AES_LAST_ROUND_EN
        drive(0, 1, 1, 1, 128'h13111d7fe3944a17f307a78b4d2b30c5, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
        @(negedge clk); check_lit("enc_last", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        drive(0, 1, 0, 1, 128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        @(negedge clk); check_lit("dec_last", 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b1);
`endif

        drive(1, 1, 1, 0, K1, P0);
        @(negedge clk); check_lit("reset_with_valid", '0, 1'b0);
        drive(0, 0, 1, 0, K1, P0);
        @(negedge clk); check_lit("after_reset_idle", '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [127:0] k;
            logic [127:0] d;
            logic         lr;
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            d  = ($urandom_range(3) == 0) ? result : {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef AES_LAST_ROUND_EN
            lr = ($urandom_range(3) == 0);
`else
            lr = 1'b0;
`endif
            drive(($urandom_range(31) == 0), ($urandom_range(3) != 0), $urandom_range(1) == 1, lr, k, d);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, '0, '0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/general_round_de.md
Name: general_round_de

Overview:
- Single AES-128 round datapath, selectable direction, one registered output stage.
- Encrypt: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
- Decrypt (straight inverse cipher): AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes.
- Iterated by the round controller in the AES core; it supplies one round key per use from the key schedule.

Parameters:
- None. Widths fixed at 128 bits, AES-128 only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies encrypt/keyword/input_data in this cycle.
- encrypt  in  1  1 = forward round, 0 = inverse round.
- keyword  in  128  round key for this round.
- input_data  in  128  state in.
- result  out  128  registered round output.
- out_valid  out  1  result holds a new value.

Behaviour:
- Byte/state mapping:
  - bits [127:120] = byte 0; byte n = bits [127-8n -: 8].
  - state s[r][c] = byte 4c+r (column-major, FIPS-197).
- Encrypt datapath:
  - SubBytes: S-box on each byte.
  - ShiftRows: row r rotated left by r.
  - MixColumns: matrix {02,03,01,01} circulant over GF(2^8), polynomial 0x11B.
  - Then XOR keyword.
- Decrypt datapath:
  - XOR keyword.
  - InvMixColumns: matrix {0e,0b,0d,09} circulant.
  - InvShiftRows: row r rotated right by r.
  - InvSubBytes.
- The decrypt path is the exact inverse of the encrypt path for the same keyword.
- Datapath is combinational; result and out_valid are registered.
- Latency 1 clock. Throughput 1 round per clock; no back-pressure.
- On a rising edge with in_valid=1: result <= f(encrypt, keyword, input_data); out_valid <= 1.
- On a rising edge with in_valid=0: result holds its value; out_valid <= 0.
- Reset: on a rising edge with rst=1, result <= 0 and out_valid <= 0. Reset takes priority over in_valid.
- Reset mid-stream: the in-flight round is discarded and no out_valid is produced for it.
- encrypt is sampled per beat. Back-to-back beats may alternate direction with no bubble.
- No X propagation: all-zero inputs give defined outputs.
  - Encrypt, zero key, zero data -> 636363...63.

Optional Feature:
- Macro AES_LAST_ROUND_EN.
- When defined:
  - Adds input port last_round (1 bit), sampled with in_valid.
  - last_round=1 bypasses MixColumns (encrypt) or InvMixColumns (decrypt), giving the AES final/first round.
- When undefined:
  - No last_round port; the MixColumns stage is always applied.

Decomposition:
- Package aes_pkg:
  - state_t typedef (16 x 8-bit).
  - SBOX and INV_SBOX 256-entry constant arrays.
  - xtime / gf_mul functions.
  - to_state / from_state byte-mapping functions.
- One sub-module, aes_mix_column:
  - 32-bit column in/out plus inverse select.
  - Instantiated 4 times.

Test Plan:
- Decrypt: keyword d6aa74fdd2af72fadaa678f1d6ab76fe, input 89d810e8855ace682d1843d8cb128fe4, encrypt=0 -> next cycle result 00102030405060708090a0b0c0d0e0f0, out_valid=1.
- Encrypt, same key: input 00102030405060708090a0b0c0d0e0f0, encrypt=1 -> result 89d810e8855ace682d1843d8cb128fe4.
- Encrypt: keyword b692cf0b643dbdf1be9bc5006830b3fe, input 89d810e8855ace682d1843d8cb128fe4 -> 4915598f55e5d7a0daca94fa1f0a63f7. Then decrypt 4915598f55e5d7a0daca94fa1f0a63f7 with the same key on the very next cycle -> 89d810e8855ace682d1843d8cb128fe4 (back-to-back, direction switch).
- Reset: assert rst with in_valid=1 and any data -> result=0, out_valid=0. Deassert with in_valid=0 -> result stays 0, out_valid stays 0.
- AES_LAST_ROUND_EN, encrypt, last_round=1: keyword 13111d7fe3944a17f307a78b4d2b30c5, input bd6e7c3df2b5779e0b61216e8b10b689 -> 69c4e0d86a7b0430d8cdb78070b4c55a. Decrypt with last_round=1 on that output -> bd6e7c3df2b5779e0b61216e8b10b689.
- Hold: in_valid=0 for 3 cycles after a valid beat -> result unchanged, out_valid=0.
